// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame-buffer scan reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    SHOW  = 2'd3
  } scan_state_t;

  localparam int LED_ROWS  = 8;
  localparam int LED_COLS  = 8;
  localparam int PIX_W     = 4;
  localparam int PWM_SLOTS = 16;
  localparam int SLOT_W    = 4;

  // Gamma curve, entry i at bits [i*PIX_W +: PIX_W]:
  // 0,0,0,1,1,2,2,3,4,5,6,8,9,11,13,15
  localparam logic [PWM_SLOTS*PIX_W-1:0] GAMMA_LUT = {
    4'd15, 4'd13, 4'd11, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4,
    4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
  };

  function automatic logic [PIX_W-1:0] gamma_map(input logic [PIX_W-1:0] v);
    return GAMMA_LUT[int'(v)*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/led_scan_reader_pwm_timer.sv
// PWM slot timer: PWM_DIV-cycle divider feeding a 4-bit slot counter.
// Latency: start pulse -> slot 0 / divider 0 in the following cycle.
// Backpressure: none; runs freely for 16 slots once started, then stops.
// Ports: clk/rst (sync, active-high); start begins a 16-slot run;
//        clear aborts and zeroes; slot = current slot index;
//        slot_end = last divider cycle of a slot; last = final cycle of slot 15.
module led_pwm_timer
  import led_pkg::*;
#(
  parameter int PWM_DIV = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot,
  output logic              slot_end,
  output logic              last
);

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PWM_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             active;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      active  <= 1'b0;
      div_cnt <= '0;
      slot    <= '0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      slot    <= '0;
    end else if (active) begin
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        // Slot wraps 15->0 only here, at the very end of the run.
        slot    <= slot + 1'b1;
        if (slot == SLOT_W'(PWM_SLOTS - 1)) begin
          active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign slot_end = active && (div_cnt == DIV_MAX);
  assign last     = slot_end && (slot == SLOT_W'(PWM_SLOTS - 1));

endmodule

// File: rtl/led_scan_reader.sv
// LED matrix scan reader: loads one 8-pixel row from the frame buffer, blanks, then PWMs it.
// Latency: 9 load + BLANK_CYCLES blank + 16*PWM_DIV show cycles per row; drives are registered.
// Backpressure: none; rows always complete, en is sampled only in IDLE and at end of a row.
// Ports: clk/rst (sync, active-high); en scan enable; rd_row/rd_col/rd_data frame-buffer
//        read port (data one cycle after address); row_sel one-hot row drive;
//        col_out column drive; frame_tick pulse after row 7; busy = not IDLE.
// Build option: define LED_SCAN_GAMMA_EN to pass captured pixels through the gamma table.
module led_scan_reader
  import led_pkg::*;
#(
  parameter int PWM_DIV      = 64,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [2:0]          rd_row,
  output logic [2:0]          rd_col,
  input  logic [PIX_W-1:0]    rd_data,
  output logic [LED_ROWS-1:0] row_sel,
  output logic [LED_COLS-1:0] col_out,
  output logic                frame_tick,
  output logic                busy
);

  scan_state_t state, nxt_state;

  logic [2:0]          row, nxt_row;
  logic [3:0]          load_cnt;
  logic [7:0]          blank_cnt;
  logic [PIX_W-1:0]    pix [LED_COLS];
  logic [PIX_W-1:0]    pix_in;
  logic [2:0]          cap_idx;

  logic [SLOT_W-1:0]   slot, slot_nxt;
  logic                slot_end, show_last;
  logic                tmr_start, tmr_clear;

  logic [LED_ROWS-1:0] row_sel_nxt;
  logic [LED_COLS-1:0] col_out_nxt;
  logic                frame_tick_nxt;

  led_pwm_timer #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .clear    (tmr_clear),
    .slot     (slot),
    .slot_end (slot_end),
    .last     (show_last)
  );

`ifdef LED_SCAN_GAMMA_EN
  assign pix_in = gamma_map(rd_data);
`else
  assign pix_in = rd_data;
`endif

  // Load cycle k (1..8) captures the data addressed in cycle k-1.
  assign cap_idx = 3'(load_cnt - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state      = state;
    nxt_row        = row;
    tmr_start      = 1'b0;
    frame_tick_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          nxt_state = LOAD;
          nxt_row   = '0;
        end
      end
      LOAD: begin
        if (load_cnt == 4'(LED_COLS)) begin
          nxt_state = BLANK;
        end
      end
      BLANK: begin
        if (blank_cnt == 8'(BLANK_CYCLES - 1)) begin
          nxt_state = SHOW;
          tmr_start = 1'b1;
        end
      end
      SHOW: begin
        if (show_last) begin
          frame_tick_nxt = (row == 3'd7);
          if (en) begin
            nxt_state = LOAD;
            nxt_row   = row + 3'd1;
          end else begin
            nxt_state = IDLE;
            nxt_row   = '0;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase

    tmr_clear = (state == IDLE);

    // Slot index that will be current next cycle; lets the drives be registered
    // yet still change exactly on slot boundaries.
    slot_nxt = '0;
    if (state == SHOW && !show_last) begin
      slot_nxt = slot_end ? slot + 1'b1 : slot;
    end

    row_sel_nxt = '0;
    col_out_nxt = '0;
    if (nxt_state == SHOW) begin
      row_sel_nxt = LED_ROWS'(1) << nxt_row;
      for (int c = 0; c < LED_COLS; c++) begin
        col_out_nxt[c] = (pix[c] > slot_nxt);
      end
    end

    rd_row = row;
    rd_col = '0;
    if (state == LOAD) begin
      rd_col = (load_cnt > 4'd7) ? 3'd7 : load_cnt[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      load_cnt   <= '0;
      blank_cnt  <= '0;
      row_sel    <= '0;
      col_out    <= '0;
      frame_tick <= 1'b0;
      for (int c = 0; c < LED_COLS; c++) begin
        pix[c] <= '0;
      end
    end else begin
      row        <= nxt_row;
      row_sel    <= row_sel_nxt;
      col_out    <= col_out_nxt;
      frame_tick <= frame_tick_nxt;
      load_cnt   <= (state == LOAD && load_cnt != 4'(LED_COLS)) ? load_cnt + 4'd1 : 4'd0;
      blank_cnt  <= (state == BLANK && nxt_state == BLANK) ? blank_cnt + 8'd1 : 8'd0;
      if (state == LOAD && load_cnt != 4'd0) begin
        pix[cap_idx] <= pix_in;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
